dmi_arbiter: RTL and testbench

//  Shares one downstream DMI port between two upstream DMI masters: in0 (JTAG DTM) and in1 (host/tap injector).

---
 rtl/dmi_arb_pkg.sv | 11 +
 rtl/dmi_arb_rr2.sv | 9 +
 rtl/dmi_arbiter.sv | 135 +++++++++++++
 tb/tb_dmi_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmi_arb_pkg.sv
// dmi_arb_pkg: shared state encoding and DMI op/response codes for the DMI arbiter.
package dmi_arb_pkg;
    typedef enum logic [2:0] {IDLE, REQ, RESP, TOUT, DRAIN} state_t;
    localparam logic [1:0] DMI_OP_NOP = 2'd0;
    localparam logic [1:0] DMI_OP_RD = 2'd1;
    localparam logic [1:0] DMI_OP_WR = 2'd2;
    localparam logic [1:0] DMI_RESP_OK = 2'd0;
    localparam logic [1:0] DMI_RESP_FAILED = 2'd2;
    localparam logic [1:0] DMI_RESP_BUSY = 2'd3;
    localparam logic [1:0] DMI_ARB_RESP_FAILED = DMI_RESP_FAILED;
endpackage

// File: rtl/dmi_arb_rr2.sv
// dmi_arb_rr2: 2-way round-robin pick; on a tie the master that was not granted last wins.
module dmi_arb_rr2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);
    assign grant[0] = valid[0] & (~valid[1] | last_grant);
    assign grant[1] = valid[1] & (~valid[0] | ~last_grant);
endmodule

// File: rtl/dmi_arbiter.sv
// dmi_arbiter: shares one downstream DMI port between two masters, one transaction in flight.
// Optional response timeout enabled by defining DMI_ARB_TIMEOUT_EN.
module dmi_arbiter
    import dmi_arb_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              dmiClock,
    input  logic              dmiReset,
    input  logic              dmi_in0_dmi_req_valid,
    output logic              dmi_in0_dmi_req_ready,
    input  logic [ADDR_W-1:0] dmi_in0_dmi_req_bits_addr,
    input  logic [1:0]        dmi_in0_dmi_req_bits_op,
    input  logic [DATA_W-1:0] dmi_in0_dmi_req_bits_data,
    output logic              dmi_in0_dmi_resp_valid,
    input  logic              dmi_in0_dmi_resp_ready,
    output logic [1:0]        dmi_in0_dmi_resp_bits_resp,
    output logic [DATA_W-1:0] dmi_in0_dmi_resp_bits_data,
    input  logic              dmi_in1_dmi_req_valid,
    output logic              dmi_in1_dmi_req_ready,
    input  logic [ADDR_W-1:0] dmi_in1_dmi_req_bits_addr,
    input  logic [1:0]        dmi_in1_dmi_req_bits_op,
    input  logic [DATA_W-1:0] dmi_in1_dmi_req_bits_data,
    output logic              dmi_in1_dmi_resp_valid,
    input  logic              dmi_in1_dmi_resp_ready,
    output logic [1:0]        dmi_in1_dmi_resp_bits_resp,
    output logic [DATA_W-1:0] dmi_in1_dmi_resp_bits_data,
    output logic              dmi_out_dmi_req_valid,
    input  logic              dmi_out_dmi_req_ready,
    output logic [ADDR_W-1:0] dmi_out_dmi_req_bits_addr,
    output logic [1:0]        dmi_out_dmi_req_bits_op,
    output logic [DATA_W-1:0] dmi_out_dmi_req_bits_data,
    input  logic              dmi_out_dmi_resp_valid,
    output logic              dmi_out_dmi_resp_ready,
    input  logic [1:0]        dmi_out_dmi_resp_bits_resp,
    input  logic [DATA_W-1:0] dmi_out_dmi_resp_bits_data,
    output logic              dmi_timeout
);
    state_t            state, state_n;
    logic              last_grant, owner, accept, owner_ready, done, tout_hit;
    logic [1:0]        grant;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        op_q;
    logic [DATA_W-1:0] data_q;
    logic              up_valid;
    logic [1:0]        up_resp;
    logic [DATA_W-1:0] up_data;

    dmi_arb_rr2 u_rr2 (
        .valid      ({dmi_in1_dmi_req_valid, dmi_in0_dmi_req_valid}),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign accept = (state == IDLE) && |grant;
    assign owner_ready = owner ? dmi_in1_dmi_resp_ready : dmi_in0_dmi_resp_ready;
    assign done = owner_ready && ((state == RESP && dmi_out_dmi_resp_valid) || state == TOUT);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = accept ? REQ : IDLE;
            REQ:     state_n = dmi_out_dmi_req_ready ? RESP : REQ;
            RESP:    state_n = (dmi_out_dmi_resp_valid && owner_ready) ? IDLE : tout_hit ? TOUT : RESP;
            TOUT:    state_n = owner_ready ? DRAIN : TOUT;
            DRAIN:   state_n = dmi_out_dmi_resp_valid ? IDLE : DRAIN;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge dmiClock or posedge dmiReset) begin
        if (dmiReset) begin
            state <= IDLE;
            last_grant <= 1'b1;
            owner <= 1'b0;
            addr_q <= '0;
            op_q <= '0;
            data_q <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                owner <= grant[1];
                addr_q <= grant[1] ? dmi_in1_dmi_req_bits_addr : dmi_in0_dmi_req_bits_addr;
                op_q <= grant[1] ? dmi_in1_dmi_req_bits_op : dmi_in0_dmi_req_bits_op;
                data_q <= grant[1] ? dmi_in1_dmi_req_bits_data : dmi_in0_dmi_req_bits_data;
            end
            if (done) last_grant <= owner;
        end
    end

`ifdef DMI_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    logic [CW-1:0] cnt;
    logic          timeout_q;
    assign tout_hit = (state == RESP) && !dmi_out_dmi_resp_valid && (cnt == CW'(TIMEOUT_CYCLES - 1));
    assign dmi_timeout = timeout_q;
    always_ff @(posedge dmiClock or posedge dmiReset) begin
        if (dmiReset) begin
            cnt <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt <= (state == RESP) ? cnt + CW'(!dmi_out_dmi_resp_valid) : '0;
            timeout_q <= tout_hit;
        end
    end
`else
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
    assign tout_hit = 1'b0;
    assign dmi_timeout = 1'b0;
`endif

    // Ready is masked during reset so no master sees an accept while the arbiter is held.
    assign dmi_in0_dmi_req_ready = !dmiReset && accept && grant[0];
    assign dmi_in1_dmi_req_ready = !dmiReset && accept && grant[1];

    assign dmi_out_dmi_req_valid = (state == REQ);
    assign dmi_out_dmi_req_bits_addr = addr_q;
    assign dmi_out_dmi_req_bits_op = op_q;
    assign dmi_out_dmi_req_bits_data = data_q;
    assign dmi_out_dmi_resp_ready = (state == RESP) ? owner_ready : (state == DRAIN);

    assign up_valid = (state == RESP) ? dmi_out_dmi_resp_valid : (state == TOUT);
    assign up_resp = (state == RESP) ? dmi_out_dmi_resp_bits_resp : (state == TOUT) ? DMI_ARB_RESP_FAILED : DMI_RESP_OK;
    assign up_data = (state == RESP) ? dmi_out_dmi_resp_bits_data : '0;

    assign dmi_in0_dmi_resp_valid = up_valid && !owner;
    assign dmi_in0_dmi_resp_bits_resp = owner ? DMI_RESP_OK : up_resp;
    assign dmi_in0_dmi_resp_bits_data = owner ? '0 : up_data;
    assign dmi_in1_dmi_resp_valid = up_valid && owner;
    assign dmi_in1_dmi_resp_bits_resp = owner ? up_resp : DMI_RESP_OK;
    assign dmi_in1_dmi_resp_bits_data = owner ? up_data : '0;
endmodule

// File: tb/tb_dmi_arbiter.sv
// tb_dmi_arbiter: vector table plus directed sequences for arbitration, stalls, reset and timeout.
module tb_dmi_arbiter;
    import dmi_arb_pkg::*;

    logic        clk = 1'b0, rst;
    logic        v0, v1, r0, r1, oqr, orv;
    logic        rdy0, rdy1, rv0, rv1, oqv, orr, tmo;
    logic [6:0]  a0, a1, oaddr;
    logic [1:0]  op0, op1, oop, rsp0, rsp1, orsp;
    logic [31:0] wd0, wd1, od, d0, d1, odata;
    int          tests = 0, errors = 0;

    typedef struct {
        logic v0, v1, oqr, orv, r0, r1;
        logic [31:0] od;
        logic e_rdy0, e_rdy1, e_oqv;
        logic [6:0] e_addr;
        logic e_orr, e_rv0, e_rv1;
        logic [31:0] e_d0, e_d1;
    } vec_t;
    vec_t vt[$];

    always #5 clk = ~clk;

    dmi_arbiter #(.ADDR_W(7), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
        .dmiClock(clk), .dmiReset(rst),
        .dmi_in0_dmi_req_valid(v0), .dmi_in0_dmi_req_ready(rdy0),
        .dmi_in0_dmi_req_bits_addr(a0), .dmi_in0_dmi_req_bits_op(op0), .dmi_in0_dmi_req_bits_data(wd0),
        .dmi_in0_dmi_resp_valid(rv0), .dmi_in0_dmi_resp_ready(r0),
        .dmi_in0_dmi_resp_bits_resp(rsp0), .dmi_in0_dmi_resp_bits_data(d0),
        .dmi_in1_dmi_req_valid(v1), .dmi_in1_dmi_req_ready(rdy1),
        .dmi_in1_dmi_req_bits_addr(a1), .dmi_in1_dmi_req_bits_op(op1), .dmi_in1_dmi_req_bits_data(wd1),
        .dmi_in1_dmi_resp_valid(rv1), .dmi_in1_dmi_resp_ready(r1),
        .dmi_in1_dmi_resp_bits_resp(rsp1), .dmi_in1_dmi_resp_bits_data(d1),
        .dmi_out_dmi_req_valid(oqv), .dmi_out_dmi_req_ready(oqr),
        .dmi_out_dmi_req_bits_addr(oaddr), .dmi_out_dmi_req_bits_op(oop), .dmi_out_dmi_req_bits_data(odata),
        .dmi_out_dmi_resp_valid(orv), .dmi_out_dmi_resp_ready(orr),
        .dmi_out_dmi_resp_bits_resp(orsp), .dmi_out_dmi_resp_bits_data(od),
        .dmi_timeout(tmo)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        {v0, v1, r0, r1, oqr, orv} = '0;
        od = '0;
        orsp = DMI_RESP_OK;
    endtask

    task automatic do_reset(input bit check);
        idle_inputs();
        v0 = 1'b1;
        rst = 1'b1;
        #2;
        if (check) begin
            chk("rst.rdy0", rdy0, 0);
            chk("rst.rdy1", rdy1, 0);
            chk("rst.oqv", oqv, 0);
            chk("rst.orr", orr, 0);
            chk("rst.addr", oaddr, 0);
            chk("rst.rv0", rv0, 0);
            chk("rst.tmo", tmo, 0);
        end
        tick();
        rst = 1'b0;
        v0 = 1'b0;
    endtask

    function automatic vec_t mk(input logic i_v0, i_v1, i_oqr, i_orv, i_r0, i_r1, input logic [31:0] i_od,
                                input logic x_rdy0, x_rdy1, x_oqv, input logic [6:0] x_addr,
                                input logic x_orr, x_rv0, x_rv1, input logic [31:0] x_d0, x_d1);
        vec_t v;
        v = '{i_v0, i_v1, i_oqr, i_orv, i_r0, i_r1, i_od, x_rdy0, x_rdy1, x_oqv, x_addr, x_orr, x_rv0, x_rv1, x_d0, x_d1};
        return v;
    endfunction

    initial begin
        a0 = 7'h11; op0 = DMI_OP_RD; wd0 = 32'h0;
        a1 = 7'h22; op1 = DMI_OP_WR; wd1 = 32'h12345678;
        // v0 v1 oqr orv r0 r1 od | rdy0 rdy1 oqv addr orr rv0 rv1 d0 d1
        vt.push_back(mk(1,0,0,0,0,0,0,            1,0,0,7'h00,0,0,0,0,0));
        vt.push_back(mk(0,0,1,0,0,0,0,            0,0,1,7'h11,0,0,0,0,0));
        vt.push_back(mk(0,0,0,1,1,0,32'hCAFEF00D, 0,0,0,7'h11,1,1,0,32'hCAFEF00D,0));
        vt.push_back(mk(0,0,0,1,1,1,32'hDEADBEEF, 0,0,0,7'h11,0,0,0,0,0));
        vt.push_back(mk(1,1,0,0,0,0,0,            0,1,0,7'h11,0,0,0,0,0));
        vt.push_back(mk(1,1,0,1,1,1,32'hDEADBEEF, 0,0,1,7'h22,0,0,0,0,0));
        for (int i = 0; i < 4; i++) vt.push_back(mk(1,1,0,0,0,0,0, 0,0,1,7'h22,0,0,0,0,0));
        vt.push_back(mk(0,0,1,0,0,0,0,            0,0,1,7'h22,0,0,0,0,0));
        for (int i = 0; i < 3; i++) vt.push_back(mk(0,0,0,1,1,0,32'hA5A5A5A5, 0,0,0,7'h22,0,0,1,0,32'hA5A5A5A5));
        vt.push_back(mk(0,0,0,1,0,1,32'hA5A5A5A5, 0,0,0,7'h22,1,0,1,0,32'hA5A5A5A5));
        vt.push_back(mk(1,1,0,0,0,0,0,            1,0,0,7'h22,0,0,0,0,0));
        vt.push_back(mk(0,0,1,0,0,0,0,            0,0,1,7'h11,0,0,0,0,0));
        vt.push_back(mk(0,0,0,0,0,1,0,            0,0,0,7'h11,0,0,0,0,0));
        vt.push_back(mk(0,0,0,1,1,0,32'h0BADBEEF, 0,0,0,7'h11,1,1,0,32'h0BADBEEF,0));
        vt.push_back(mk(0,1,0,0,0,0,0,            0,1,0,7'h11,0,0,0,0,0));
        vt.push_back(mk(0,0,1,0,0,0,0,            0,0,1,7'h22,0,0,0,0,0));
        vt.push_back(mk(0,0,0,1,0,1,32'h11112222, 0,0,0,7'h22,1,0,1,0,32'h11112222));

        do_reset(1);
        foreach (vt[i]) begin
            {v0, v1, oqr, orv, r0, r1} = {vt[i].v0, vt[i].v1, vt[i].oqr, vt[i].orv, vt[i].r0, vt[i].r1};
            od = vt[i].od;
            #2;
            chk($sformatf("v%0d.rdy0", i), rdy0, vt[i].e_rdy0);
            chk($sformatf("v%0d.rdy1", i), rdy1, vt[i].e_rdy1);
            chk($sformatf("v%0d.oqv", i), oqv, vt[i].e_oqv);
            chk($sformatf("v%0d.addr", i), oaddr, vt[i].e_addr);
            chk($sformatf("v%0d.orr", i), orr, vt[i].e_orr);
            chk($sformatf("v%0d.rv0", i), rv0, vt[i].e_rv0);
            chk($sformatf("v%0d.rv1", i), rv1, vt[i].e_rv1);
            chk($sformatf("v%0d.d0", i), d0, vt[i].e_d0);
            chk($sformatf("v%0d.d1", i), d1, vt[i].e_d1);
            tick();
        end

        // Alternating grants under continuous contention from reset.
        do_reset(0);
        for (int i = 0; i < 4; i++) begin
            bit g;
            g = i[0];
            idle_inputs();
            v0 = 1'b1; v1 = 1'b1;
            #2;
            chk($sformatf("alt%0d.rdy0", i), rdy0, !g);
            chk($sformatf("alt%0d.rdy1", i), rdy1, g);
            tick();
            idle_inputs();
            oqr = 1'b1;
            #2;
            chk($sformatf("alt%0d.oqv", i), oqv, 1);
            chk($sformatf("alt%0d.addr", i), oaddr, g ? 7'h22 : 7'h11);
            chk($sformatf("alt%0d.op", i), oop, g ? DMI_OP_WR : DMI_OP_RD);
            chk($sformatf("alt%0d.wdata", i), odata, g ? 32'h12345678 : 32'h0);
            tick();
            idle_inputs();
            orv = 1'b1; r0 = 1'b1; r1 = 1'b1;
            od = 32'h1000 + i;
            orsp = (i == 3) ? DMI_RESP_BUSY : (i == 2) ? DMI_RESP_FAILED : DMI_RESP_OK;
            #2;
            chk($sformatf("alt%0d.rv0", i), rv0, !g);
            chk($sformatf("alt%0d.rv1", i), rv1, g);
            chk($sformatf("alt%0d.data", i), g ? d1 : d0, 32'h1000 + i);
            chk($sformatf("alt%0d.resp", i), g ? rsp1 : rsp0, (i == 3) ? 2'd3 : (i == 2) ? 2'd2 : 2'd0);
            tick();
            idle_inputs();
            #2;
            chk($sformatf("alt%0d.idle_rv", i), {rv0, rv1}, 2'b00);
            tick();
        end

        // Reset while a response is pending, then a normal in1 transaction.
        idle_inputs();
        v0 = 1'b1;
        tick();
        idle_inputs();
        oqr = 1'b1;
        tick();
        idle_inputs();
        orv = 1'b1; r0 = 1'b1; v1 = 1'b1; od = 32'h55555555;
        rst = 1'b1;
        #1;
        chk("mrst.rv0", rv0, 0);
        chk("mrst.d0", d0, 0);
        chk("mrst.orr", orr, 0);
        chk("mrst.oqv", oqv, 0);
        chk("mrst.rdy1", rdy1, 0);
        chk("mrst.addr", oaddr, 0);
        tick();
        rst = 1'b0;
        orv = 1'b0; r0 = 1'b0;
        #2;
        chk("mrst.rv0_after", rv0, 0);
        chk("mrst.rdy1_after", rdy1, 1);
        tick();
        idle_inputs();
        oqr = 1'b1;
        #2;
        chk("mrst.addr1", oaddr, 7'h22);
        tick();
        idle_inputs();
        orv = 1'b1; r1 = 1'b1; od = 32'h77777777;
        #2;
        chk("mrst.rv1", rv1, 1);
        chk("mrst.d1", d1, 32'h77777777);
        chk("mrst.rv0_none", rv0, 0);
        tick();
        idle_inputs();

`ifdef DMI_ARB_TIMEOUT_EN
        v0 = 1'b1;
        tick();
        idle_inputs();
        oqr = 1'b1;
        tick();
        idle_inputs();
        for (int k = 0; k < 8; k++) begin
            #2;
            chk($sformatf("to.wait%0d.tmo", k), tmo, 0);
            chk($sformatf("to.wait%0d.rv0", k), rv0, 0);
            tick();
        end
        #2;
        chk("to.pulse", tmo, 1);
        chk("to.rv0", rv0, 1);
        chk("to.resp", rsp0, 2'd2);
        chk("to.data", d0, 0);
        chk("to.rv1", rv1, 0);
        tick();
        #2;
        chk("to.pulse_end", tmo, 0);
        chk("to.rv0_hold", rv0, 1);
        r0 = 1'b1;
        tick();
        idle_inputs();
        v0 = 1'b1;
        orv = 1'b1; od = 32'hDEADDEAD;
        #2;
        chk("drain.orr", orr, 1);
        chk("drain.rdy0", rdy0, 0);
        chk("drain.rv", {rv0, rv1}, 2'b00);
        tick();
        idle_inputs();
        v0 = 1'b1;
        #2;
        chk("post.rdy0", rdy0, 1);
        tick();
        idle_inputs();
        oqr = 1'b1;
        tick();
        idle_inputs();
        orv = 1'b1; r0 = 1'b1; od = 32'h0000600D;
        #2;
        chk("post.rv0", rv0, 1);
        chk("post.d0", d0, 32'h0000600D);
        tick();
        idle_inputs();
`else
        orsp = DMI_RESP_OK;
        op0 = DMI_OP_NOP;
        #2;
        chk("notmo", tmo, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
